// File: rtl/stk_ptr_pool_if.sv
// Bundle of the pool's admission, lookup, return and status signals.
// master = pipeline side driving requests, slave = the pointer pool.
interface stk_ptr_pool_if #(
  parameter int PTR_W = 4
);
  logic             i_ad_alloc;
  logic             o_ad_empty;
  logic             o_ad_busy;
  logic             o_lk_ptr_vld;
  logic [PTR_W-1:0] o_lk_ptr_w;
  logic             i_dealloc_vld;
  logic [PTR_W-1:0] i_dealloc_ptr;
  logic [PTR_W:0]   o_free_cnt;
  logic             o_err_underflow;
  logic             o_err_overflow;

  modport master (
    output i_ad_alloc, i_dealloc_vld, i_dealloc_ptr,
    input  o_ad_empty, o_ad_busy, o_lk_ptr_vld, o_lk_ptr_w,
    input  o_free_cnt, o_err_underflow, o_err_overflow
  );

  modport slave (
    input  i_ad_alloc, i_dealloc_vld, i_dealloc_ptr,
    output o_ad_empty, o_ad_busy, o_lk_ptr_vld, o_lk_ptr_w,
    output o_free_cnt, o_err_underflow, o_err_overflow
  );
endinterface

// File: rtl/stk_ptr_pool.sv
// Free-pointer pool: LIFO of unallocated descriptor pointers with one grant
// and one return per cycle, alloc/return bypass and error pulses.
//
// state   | meaning
// --------+-----------------------------------------------------------
// S_INIT  | filling stk[] with N-1 downto RSVD_N, one entry per cycle
// S_READY | serving allocations and returns
module stk_ptr_pool #(
  parameter int PTR_W  = 4,
  parameter int RSVD_N = 1
) (
  input  logic          clk,
  input  logic          arst_n,
  stk_ptr_pool_if.slave bus
);
  localparam int N = 2 ** PTR_W;
  localparam logic [PTR_W:0]   LIMIT    = (PTR_W+1)'(N - RSVD_N);
  localparam logic [PTR_W:0]   LIMIT_M1 = (PTR_W+1)'(N - RSVD_N - 1);
  localparam logic [PTR_W-1:0] RSVD_V   = PTR_W'(RSVD_N);
  localparam logic [PTR_W-1:0] MAXP     = PTR_W'(N - 1);
  localparam logic [PTR_W-1:0] ONE_P    = PTR_W'(1);
  localparam logic [PTR_W:0]   ONE_S    = (PTR_W+1)'(1);

  typedef enum logic {S_INIT, S_READY} state_t;

  state_t           r_state;
  logic [PTR_W:0]   r_sp;
  logic [PTR_W-1:0] r_stk [N];
  logic [PTR_W-1:0] r_ptr;
  logic             r_vld;
  logic             r_under;
  logic             r_over;

  logic             w_ready;
  logic             w_legal_d;
  logic             w_bad_d;
  logic             w_bypass;
  logic             w_pop;
  logic             w_push;
  logic             w_underflow;
  logic             w_overflow;
  logic [PTR_W-1:0] w_wr_idx;
  logic [PTR_W-1:0] w_top_idx;
  logic [PTR_W-1:0] w_init_val;

  assign w_ready   = (r_state == S_READY);
  // Returns of reserved pointers are rejected; an alloc in the same cycle
  // then falls back to a normal pop.
  assign w_legal_d = bus.i_dealloc_vld && (bus.i_dealloc_ptr >= RSVD_V);
  assign w_bad_d   = bus.i_dealloc_vld && !w_legal_d;
  assign w_bypass  = w_ready && bus.i_ad_alloc && w_legal_d;
  assign w_pop     = w_ready && bus.i_ad_alloc && !w_legal_d && (r_sp != '0);
  assign w_push    = w_ready && !bus.i_ad_alloc && w_legal_d && (r_sp < LIMIT);

  assign w_underflow = bus.i_ad_alloc &&
                       (!w_ready || (!w_legal_d && (r_sp == '0)));
  assign w_overflow  = bus.i_dealloc_vld &&
                       (!w_ready || w_bad_d || (!bus.i_ad_alloc && (r_sp >= LIMIT)));

  assign w_wr_idx   = r_sp[PTR_W-1:0];
  assign w_top_idx  = r_sp[PTR_W-1:0] - ONE_P;
  assign w_init_val = MAXP - r_sp[PTR_W-1:0];

  // Stack storage: init fill or push of a returned pointer; no reset needed
  // because sp bounds which entries are meaningful.
  always_ff @(posedge clk) begin
    if (!w_ready) begin
      r_stk[w_wr_idx] <= w_init_val;
    end else if (w_push) begin
      r_stk[w_wr_idx] <= bus.i_dealloc_ptr;
    end
  end

  // FSM, stack pointer, grant register and error pulses.
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      r_state <= S_INIT;
      r_sp    <= '0;
      r_ptr   <= '0;
      r_vld   <= 1'b0;
      r_under <= 1'b0;
      r_over  <= 1'b0;
    end else begin
      r_under <= w_underflow;
      r_over  <= w_overflow;
      r_vld   <= w_bypass || w_pop;
      if (w_bypass) begin
        r_ptr <= bus.i_dealloc_ptr;
      end else if (w_pop) begin
        r_ptr <= r_stk[w_top_idx];
      end
      case (r_state)
        S_INIT: begin
          r_sp <= r_sp + ONE_S;
          if (r_sp == LIMIT_M1) begin
            r_state <= S_READY;
          end
        end
        S_READY: begin
          if (w_pop) begin
            r_sp <= r_sp - ONE_S;
          end else if (w_push) begin
            r_sp <= r_sp + ONE_S;
          end
        end
        default: r_state <= S_INIT;
      endcase
    end
  end

  assign bus.o_ad_busy       = !w_ready;
  assign bus.o_ad_empty      = (r_sp == '0);
  assign bus.o_free_cnt      = r_sp;
  assign bus.o_lk_ptr_vld    = r_vld;
  assign bus.o_lk_ptr_w      = r_ptr;
  assign bus.o_err_underflow = r_under;
  assign bus.o_err_overflow  = r_over;
endmodule

// File: tb/tb_stk_ptr_pool.sv
// Bench for stk_ptr_pool (PTR_W=4, RSVD_N=1): table of request/expected
// records run through a scoreboard queue, plus hand sequences for init,
// errors during init and asynchronous reset mid-operation.
module tb_stk_ptr_pool;
  logic clk;
  logic arst_n;

  stk_ptr_pool_if #(.PTR_W(4)) bus ();

  stk_ptr_pool #(.PTR_W(4), .RSVD_N(1)) dut (
    .clk    (clk),
    .arst_n (arst_n),
    .bus    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       a;
    logic       d;
    logic [3:0] p;
    logic       e_vld;
    logic [3:0] e_ptr;
    logic [4:0] e_free;
    logic       e_under;
    logic       e_over;
  } vec_t;

  vec_t vecs[$];
  vec_t sb[$];
  int   total = 0;
  int   bad   = 0;

  function automatic vec_t mk(logic a, logic d, logic [3:0] p, logic vld,
                              logic [3:0] ptr, logic [4:0] fr, logic un, logic ov);
    vec_t v;
    v.a = a; v.d = d; v.p = p; v.e_vld = vld; v.e_ptr = ptr;
    v.e_free = fr; v.e_under = un; v.e_over = ov;
    return v;
  endfunction

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0d required=%0d", nm, act, exp);
    end
  endtask

  // Drive one request, let the edge happen, compare the registered result.
  task automatic apply(vec_t v, string tag);
    vec_t e;
    bus.i_ad_alloc    = v.a;
    bus.i_dealloc_vld = v.d;
    bus.i_dealloc_ptr = v.p;
    sb.push_back(v);
    @(posedge clk);
    #1;
    e = sb.pop_front();
    chk({tag, " vld"},   32'(bus.o_lk_ptr_vld),    32'(e.e_vld));
    chk({tag, " ptr"},   32'(bus.o_lk_ptr_w),      32'(e.e_ptr));
    chk({tag, " free"},  32'(bus.o_free_cnt),      32'(e.e_free));
    chk({tag, " empty"}, 32'(bus.o_ad_empty),      32'(e.e_free == 5'd0));
    chk({tag, " under"}, 32'(bus.o_err_underflow), 32'(e.e_under));
    chk({tag, " over"},  32'(bus.o_err_overflow),  32'(e.e_over));
    bus.i_ad_alloc    = 1'b0;
    bus.i_dealloc_vld = 1'b0;
    bus.i_dealloc_ptr = 4'd0;
  endtask

  task automatic chk_reset_vals(string tag);
    chk({tag, " busy"},  32'(bus.o_ad_busy),       32'd1);
    chk({tag, " empty"}, 32'(bus.o_ad_empty),      32'd1);
    chk({tag, " vld"},   32'(bus.o_lk_ptr_vld),    32'd0);
    chk({tag, " ptr"},   32'(bus.o_lk_ptr_w),      32'd0);
    chk({tag, " free"},  32'(bus.o_free_cnt),      32'd0);
    chk({tag, " under"}, 32'(bus.o_err_underflow), 32'd0);
    chk({tag, " over"},  32'(bus.o_err_overflow),  32'd0);
  endtask

  // Count edges until busy drops (bounded); must be 15 edges after release.
  task automatic wait_init(int start, string tag);
    int cnt = start;
    while (bus.o_ad_busy && cnt < 40) begin
      @(posedge clk);
      #1;
      cnt++;
    end
    chk({tag, " init_edges"}, 32'(cnt), 32'd15);
    chk({tag, " busy_after"}, 32'(bus.o_ad_busy), 32'd0);
    chk({tag, " free_after"}, 32'(bus.o_free_cnt), 32'd15);
    chk({tag, " empty_after"}, 32'(bus.o_ad_empty), 32'd0);
  endtask

  task automatic pulse_reset(string tag);
    #2;
    arst_n = 1'b0;
    #1;
    chk_reset_vals(tag);
    @(negedge clk);
    arst_n = 1'b1;
  endtask

  initial begin
    // Table: 15 grants, underflow, bypass on empty, LIFO returns, errors,
    // refill to full, overflow cases, bypass and bad-return on full.
    for (int i = 0; i < 15; i++)
      vecs.push_back(mk(1, 0, 0, 1, 4'(i + 1), 5'(14 - i), 0, 0));
    vecs.push_back(mk(1, 0, 0, 0, 15, 0, 1, 0));
    vecs.push_back(mk(1, 1, 7, 1, 7, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 7, 0, 0, 0));
    vecs.push_back(mk(0, 1, 3, 0, 7, 1, 0, 0));
    vecs.push_back(mk(0, 1, 9, 0, 7, 2, 0, 0));
    vecs.push_back(mk(1, 0, 0, 1, 9, 1, 0, 0));
    vecs.push_back(mk(1, 0, 0, 1, 3, 0, 0, 0));
    vecs.push_back(mk(1, 1, 0, 0, 3, 0, 1, 1));
    for (int i = 0; i < 15; i++)
      vecs.push_back(mk(0, 1, 4'(i + 1), 0, 3, 5'(i + 1), 0, 0));
    vecs.push_back(mk(0, 1, 5, 0, 3, 15, 0, 1));
    vecs.push_back(mk(0, 1, 0, 0, 3, 15, 0, 1));
    vecs.push_back(mk(1, 1, 5, 1, 5, 15, 0, 0));
    vecs.push_back(mk(1, 1, 0, 1, 15, 14, 0, 1));
    vecs.push_back(mk(1, 0, 0, 1, 14, 13, 0, 0));

    arst_n = 1'b0;
    bus.i_ad_alloc    = 1'b0;
    bus.i_dealloc_vld = 1'b0;
    bus.i_dealloc_ptr = 4'd0;
    #12;
    chk_reset_vals("rst");
    @(negedge clk);
    arst_n = 1'b1;

    // Requests during init are rejected with error pulses.
    apply(mk(1, 0, 0, 0, 0, 1, 1, 0), "init_alloc");
    chk("init_alloc busy", 32'(bus.o_ad_busy), 32'd1);
    apply(mk(0, 1, 5, 0, 0, 2, 0, 1), "init_dealloc");
    chk("init_dealloc busy", 32'(bus.o_ad_busy), 32'd1);
    wait_init(2, "init1");

    foreach (vecs[i]) apply(vecs[i], $sformatf("vec%0d", i));

    // Reset mid-operation, re-init, four grants, reset again.
    pulse_reset("rst2");
    wait_init(0, "init2");
    for (int i = 0; i < 4; i++)
      apply(mk(1, 0, 0, 1, 4'(i + 1), 5'(14 - i), 0, 0), $sformatf("g%0d", i));
    pulse_reset("rst3");
    wait_init(0, "init3");
    apply(mk(1, 0, 0, 1, 1, 14, 0, 0), "post_rst_grant");
    apply(mk(0, 0, 0, 0, 1, 14, 0, 0), "post_rst_idle");
    chk("sb_drained", 32'(sb.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/stk_ptr_pool.md
# stk_ptr_pool

Parametrised free-pointer pool for the stack pipeline: holds the set of unallocated descriptor pointers as a LIFO, serves one allocation per cycle to the admission stage, presents the granted pointer to the lookup stage on the next cycle, and accepts one returned pointer per cycle. It generalises the fixed-width allocator stage with configurable pointer width, reserved low pointers, alloc/dealloc bypass, a free-count output and error reporting.

## Interface
- PTR_W, 4: pointer width; pool depth N = 2**PTR_W.
- RSVD_N, 1: pointers 0..RSVD_N-1 are never issued (0 is null); 0 <= RSVD_N < N.
- clk  in  1  clock.
- arst_n  in  1  one clock; reset is asynchronous and active-low.
- i_ad_alloc  in  1  allocation request from admission stage.
- o_ad_empty  out  1  no free pointer in the pool.
- o_ad_busy  out  1  pool initialising; allocation not permitted.
- o_lk_ptr_vld  out  1  o_lk_ptr_w holds a newly granted pointer.
- o_lk_ptr_w  out  PTR_W  granted pointer to lookup stage.
- i_dealloc_vld  in  1  pointer return strobe.
- i_dealloc_ptr  in  PTR_W  returned pointer.
- o_free_cnt  out  PTR_W+1  number of free pointers held.
- o_err_underflow  out  1  one-cycle pulse: illegal allocation.
- o_err_overflow  out  1  one-cycle pulse: illegal return.

## Operation
- Storage: N-entry array stk[], stack pointer sp (PTR_W+1 bits) = o_free_cnt; top of stack is stk[sp-1].
- FSM: INIT -> READY. Reset enters INIT with sp=0. INIT writes stk[sp] = N-1-sp, sp++ each cycle until sp == N-RSVD_N, then READY. Top after init holds RSVD_N, so first grant is RSVD_N, then RSVD_N+1, ...
- o_ad_busy = (state==INIT); o_ad_empty = (sp==0); both decoded from registers, no input paths.
- READY, per cycle, A = i_ad_alloc, D = i_dealloc_vld, legal-D = D and i_dealloc_ptr >= RSVD_N:
  - A only, sp>0: grant stk[sp-1], sp--.
  - A only, sp==0: no grant, o_err_underflow.
  - legal-D only, sp < N-RSVD_N: stk[sp]=ptr, sp++.
  - legal-D only, sp == N-RSVD_N: push dropped, o_err_overflow.
  - A and legal-D: bypass; grant i_dealloc_ptr, sp and stk unchanged; legal even when sp==0.
  - D with ptr < RSVD_N: dropped, o_err_overflow; an A in the same cycle is then treated as A only.
- INIT: any A -> o_err_underflow, ignored; any D -> o_err_overflow, dropped.
- No duplicate-pointer detection; caller owns uniqueness.

## Timing
- Grant latency 1: A at edge t -> o_lk_ptr_vld=1, o_lk_ptr_w valid for exactly the cycle after t; o_lk_ptr_vld=0 otherwise; o_lk_ptr_w holds last value when not valid.
- Return takes effect on sp/o_free_cnt at the following edge; pointer grantable from the next cycle (or same cycle via bypass).
- Errors registered: pulse in cycle after the offending request.
- o_ad_busy stays 1 for exactly N-RSVD_N rising edges after arst_n release; deasserts with o_free_cnt = N-RSVD_N.
- Reset values: o_ad_busy=1, o_ad_empty=1, o_lk_ptr_vld=0, o_lk_ptr_w=0, o_free_cnt=0, errors=0. Assertion mid-operation aborts immediately; all issued pointers are forgotten and init restarts on release.
- Throughput: one grant and one return per cycle, no bubbles.

## Test plan
- PTR_W=4, RSVD_N=1, reset release -> busy high 15 cycles, then busy=0, empty=0, free_cnt=15.
- After init, 15 back-to-back allocs -> grants 1,2,...,15 on consecutive cycles, then empty=1, free_cnt=0; 16th alloc -> no vld, underflow pulse.
- Empty pool, alloc with dealloc ptr=7 same cycle -> next cycle vld=1, ptr=7, free_cnt stays 0, no error.
- Return 3 then 9 on empty pool -> free_cnt=2; two allocs -> grants 9 then 3 (LIFO).
- Full pool, dealloc ptr=5 -> overflow pulse, free_cnt stays 15; dealloc ptr=0 -> overflow pulse, dropped.
- Alloc during INIT and arst_n pulse after 4 grants -> underflow pulse/ignored; reset returns all outputs to reset values and init restarts, first grant again 1.
